bp_update_sched: RTL and testbench

BP_UPDATE_SCHED -- requirements
Module: bp_update_sched

---
 rtl/bp_update_sched.sv | 201 ++++++++++++++++++++
 tb/tb_bp_update_sched.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_update_sched.sv
`default_nettype none
// ============================================================================
//  Module   : bp_update_sched
//  Purpose  : Branch-predictor update scheduler. Queues resolved control-flow
//             updates from the execute stage and drains them, one per cycle,
//             into the BHT / BTB / RPCT write port. After reset or on a clear
//             request it first sweeps every set to invalidate all three tables.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk         in   rising-edge clock
//    reset       in   synchronous active-high reset
//    upd_valid   in   update request from execute stage
//    upd_ready   out  queue can accept (not full, not in reset)
//    upd_kind    in   00 cond branch, 01 direct jump, 10 jr ra/jalr, 11 drop
//    upd_pc      in   pc of the resolved instruction
//    upd_target  in   resolved target
//    upd_taken   in   resolved direction
//    clear_req   in   pulse: invalidate all tables, flush queue
//    wr_stall    in   table write port busy this cycle
//    tbl_we      out  table write strobe
//    tbl_sel     out  one-hot table select {RPCT, BTB, BHT}; 111 while clearing
//    tbl_clear   out  write an invalid (all-zero) entry
//    tbl_index   out  set index
//    tbl_pc      out  entry pc
//    tbl_target  out  entry target
//    tbl_taken   out  entry direction
//    init_done   out  high while in RUN
// ============================================================================
module bp_update_sched #(
    parameter int SET_NUM    = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       upd_valid,
    output logic                       upd_ready,
    input  logic [1:0]                 upd_kind,
    input  logic [31:0]                upd_pc,
    input  logic [31:0]                upd_target,
    input  logic                       upd_taken,
    input  logic                       clear_req,
    input  logic                       wr_stall,
    output logic                       tbl_we,
    output logic [2:0]                 tbl_sel,
    output logic                       tbl_clear,
    output logic [$clog2(SET_NUM)-1:0] tbl_index,
    output logic [31:0]                tbl_pc,
    output logic [31:0]                tbl_target,
    output logic                       tbl_taken,
    output logic                       init_done
);

    localparam int IDX_W = $clog2(SET_NUM);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(SET_NUM - 1);
    localparam logic [CNT_W-1:0] c_FULL     = CNT_W'(FIFO_DEPTH);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [IDX_W-1:0]  r_clr_idx;
    logic [IDX_W-1:0]  w_clr_idx_nxt;

    // Queue storage: data arrays carry no reset, validity is tracked by r_count.
    logic [1:0]        r_fifo_kind   [FIFO_DEPTH];
    logic [31:0]       r_fifo_pc     [FIFO_DEPTH];
    logic [31:0]       r_fifo_target [FIFO_DEPTH];
    logic              r_fifo_taken  [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    logic              w_enq;
    logic              w_deq;
    logic [1:0]        w_head_kind;
    logic [31:0]       w_head_pc;

    assign upd_ready   = !reset && (r_count != c_FULL);
    assign w_head_kind = r_fifo_kind[r_rd_ptr];
    assign w_head_pc   = r_fifo_pc[r_rd_ptr];

    // Kind 11 completes the handshake but never occupies a slot. A clear in
    // the same cycle discards the incoming entry together with the queue.
    assign w_enq = upd_valid && upd_ready && (upd_kind != 2'b11) && !clear_req;
    assign w_deq = (r_state == ST_RUN) && (r_count != '0) && !wr_stall
                   && !clear_req && !reset;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_CLEAR;
            r_clr_idx <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_idx <= w_clr_idx_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state and table-port outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_clr_idx_nxt = r_clr_idx;
        tbl_we        = 1'b0;
        tbl_sel       = 3'b000;
        tbl_clear     = 1'b0;
        tbl_index     = '0;
        tbl_pc        = '0;
        tbl_target    = '0;
        tbl_taken     = 1'b0;
        init_done     = 1'b0;

        case (r_state)
            ST_CLEAR: begin
                if (!wr_stall && !reset) begin
                    tbl_we    = 1'b1;
                    tbl_sel   = 3'b111;
                    tbl_clear = 1'b1;
                    tbl_index = r_clr_idx;
                end
                if (clear_req) begin
                    w_clr_idx_nxt = '0;
                end else if (!wr_stall) begin
                    if (r_clr_idx == c_LAST_IDX) begin
                        w_state_nxt   = ST_RUN;
                        w_clr_idx_nxt = '0;
                    end else begin
                        w_clr_idx_nxt = r_clr_idx + IDX_W'(1);
                    end
                end
            end
            ST_RUN: begin
                init_done = !reset;
                if (w_deq) begin
                    tbl_we     = 1'b1;
                    tbl_index  = w_head_pc[IDX_W+1:2];
                    tbl_pc     = w_head_pc;
                    tbl_target = r_fifo_target[r_rd_ptr];
                    tbl_taken  = r_fifo_taken[r_rd_ptr];
                    case (w_head_kind)
                        2'b00:   tbl_sel = 3'b001;
                        2'b01:   tbl_sel = 3'b010;
                        default: tbl_sel = 3'b100;
                    endcase
                end
                if (clear_req) begin
                    w_state_nxt   = ST_CLEAR;
                    w_clr_idx_nxt = '0;
                end
            end
            default: begin
                w_state_nxt   = ST_CLEAR;
                w_clr_idx_nxt = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Update queue control
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset || clear_req) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_enq) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_deq) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_fifo_kind[r_wr_ptr]   <= upd_kind;
            r_fifo_pc[r_wr_ptr]     <= upd_pc;
            r_fifo_target[r_wr_ptr] <= upd_target;
            r_fifo_taken[r_wr_ptr]  <= upd_taken;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bp_update_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bp_update_sched
//  Purpose  : Directed, table-driven self-checking bench for bp_update_sched
//             (SET_NUM=8, FIFO_DEPTH=4) plus hand-written multi-cycle cases.
//  Revision : 1.0  initial release
// ============================================================================
module tb_bp_update_sched;

    logic        clk;
    logic        reset;
    logic        upd_valid;
    logic        upd_ready;
    logic [1:0]  upd_kind;
    logic [31:0] upd_pc;
    logic [31:0] upd_target;
    logic        upd_taken;
    logic        clear_req;
    logic        wr_stall;
    logic        tbl_we;
    logic [2:0]  tbl_sel;
    logic        tbl_clear;
    logic [2:0]  tbl_index;
    logic [31:0] tbl_pc;
    logic [31:0] tbl_target;
    logic        tbl_taken;
    logic        init_done;

    int checks = 0;
    int errors = 0;

    bp_update_sched #(
        .SET_NUM    (8),
        .FIFO_DEPTH (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .upd_valid  (upd_valid),
        .upd_ready  (upd_ready),
        .upd_kind   (upd_kind),
        .upd_pc     (upd_pc),
        .upd_target (upd_target),
        .upd_taken  (upd_taken),
        .clear_req  (clear_req),
        .wr_stall   (wr_stall),
        .tbl_we     (tbl_we),
        .tbl_sel    (tbl_sel),
        .tbl_clear  (tbl_clear),
        .tbl_index  (tbl_index),
        .tbl_pc     (tbl_pc),
        .tbl_target (tbl_target),
        .tbl_taken  (tbl_taken),
        .init_done  (init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst;
        logic        vld;
        logic [1:0]  kind;
        logic [31:0] pc;
        logic [31:0] tgt;
        logic        tkn;
        logic        clr;
        logic        stall;
    } in_t;

    typedef struct packed {
        logic        rdy;
        logic        we;
        logic [2:0]  sel;
        logic        clr;
        logic [2:0]  idx;
        logic [31:0] pc;
        logic [31:0] tgt;
        logic        tkn;
        logic        done;
    } out_t;

    typedef struct packed {
        in_t  i;
        out_t o;
    } vec_t;

    vec_t tbl[$];

    // ---------------- stimulus builders ----------------
    function automatic in_t I_IDLE();
        in_t v;
        v = '0;
        return v;
    endfunction

    function automatic in_t I_RST();
        in_t v;
        v = '0;
        v.rst = 1'b1;
        return v;
    endfunction

    function automatic in_t I_STALL();
        in_t v;
        v = '0;
        v.stall = 1'b1;
        return v;
    endfunction

    function automatic in_t I_CLRQ();
        in_t v;
        v = '0;
        v.clr = 1'b1;
        return v;
    endfunction

    function automatic in_t I_ENQ(input logic [1:0] kind, input logic [31:0] pc,
                                  input logic [31:0] tgt, input logic tkn,
                                  input logic stall);
        in_t v;
        v       = '0;
        v.vld   = 1'b1;
        v.kind  = kind;
        v.pc    = pc;
        v.tgt   = tgt;
        v.tkn   = tkn;
        v.stall = stall;
        return v;
    endfunction

    // ---------------- expectation builders ----------------
    function automatic out_t O_Z(input logic rdy, input logic done);
        out_t v;
        v      = '0;
        v.rdy  = rdy;
        v.done = done;
        return v;
    endfunction

    function automatic out_t O_C(input logic [2:0] idx);
        out_t v;
        v     = '0;
        v.rdy = 1'b1;
        v.we  = 1'b1;
        v.sel = 3'b111;
        v.clr = 1'b1;
        v.idx = idx;
        return v;
    endfunction

    function automatic out_t O_W(input logic [2:0] sel, input logic [2:0] idx,
                                 input logic [31:0] pc, input logic [31:0] tgt,
                                 input logic tkn);
        out_t v;
        v      = '0;
        v.rdy  = 1'b1;
        v.we   = 1'b1;
        v.sel  = sel;
        v.idx  = idx;
        v.pc   = pc;
        v.tgt  = tgt;
        v.tkn  = tkn;
        v.done = 1'b1;
        return v;
    endfunction

    task automatic add(input in_t vi, input out_t vo);
        vec_t v;
        v.i = vi;
        v.o = vo;
        tbl.push_back(v);
    endtask

    // Drive one cycle of inputs just after the rising edge, compare the
    // combinational outputs mid-cycle on the falling edge.
    task automatic apply(input in_t vi, input out_t vo, input string nm);
        out_t act;
        @(posedge clk);
        #1;
        reset      = vi.rst;
        upd_valid  = vi.vld;
        upd_kind   = vi.kind;
        upd_pc     = vi.pc;
        upd_target = vi.tgt;
        upd_taken  = vi.tkn;
        clear_req  = vi.clr;
        wr_stall   = vi.stall;
        @(negedge clk);
        act.rdy  = upd_ready;
        act.we   = tbl_we;
        act.sel  = tbl_sel;
        act.clr  = tbl_clear;
        act.idx  = tbl_index;
        act.pc   = tbl_pc;
        act.tgt  = tbl_target;
        act.tkn  = tbl_taken;
        act.done = init_done;
        checks++;
        if (act !== vo) begin
            errors++;
            $display("FAIL %s got rdy=%b we=%b sel=%b clr=%b idx=%0d pc=%h tgt=%h tkn=%b done=%b expected rdy=%b we=%b sel=%b clr=%b idx=%0d pc=%h tgt=%h tkn=%b done=%b",
                     nm, act.rdy, act.we, act.sel, act.clr, act.idx, act.pc, act.tgt,
                     act.tkn, act.done, vo.rdy, vo.we, vo.sel, vo.clr, vo.idx, vo.pc,
                     vo.tgt, vo.tkn, vo.done);
        end
    endtask

    initial begin
        out_t o;
        reset      = 1'b1;
        upd_valid  = 1'b0;
        upd_kind   = 2'b00;
        upd_pc     = '0;
        upd_target = '0;
        upd_taken  = 1'b0;
        clear_req  = 1'b0;
        wr_stall   = 1'b0;

        // ---- reset, full sweep, enqueue accepted while clearing ----
        add(I_RST(), O_Z(1'b0, 1'b0));
        add(I_RST(), O_Z(1'b0, 1'b0));
        for (int i = 0; i < 8; i++) begin
            if (i == 1)
                add(I_ENQ(2'b01, 32'h0000_000C, 32'hAAAA_0000, 1'b1, 1'b0), O_C(3'(i)));
            else
                add(I_IDLE(), O_C(3'(i)));
        end
        add(I_IDLE(), O_W(3'b010, 3'd3, 32'h0000_000C, 32'hAAAA_0000, 1'b1));
        add(I_IDLE(), O_Z(1'b1, 1'b1));

        // ---- jr/jalr update lands one cycle after enqueue ----
        add(I_ENQ(2'b10, 32'h8000_0014, 32'h1234_5678, 1'b1, 1'b0), O_Z(1'b1, 1'b1));
        add(I_IDLE(), O_W(3'b100, 3'd5, 32'h8000_0014, 32'h1234_5678, 1'b1));
        add(I_IDLE(), O_Z(1'b1, 1'b1));

        // ---- reserved kind: handshake only, nothing written ----
        add(I_ENQ(2'b11, 32'h0000_0020, 32'h0000_0030, 1'b1, 1'b0), O_Z(1'b1, 1'b1));
        add(I_IDLE(), O_Z(1'b1, 1'b1));

        // ---- back-to-back enqueue with concurrent dequeue ----
        add(I_ENQ(2'b00, 32'h0000_001C, 32'h0000_0040, 1'b0, 1'b0), O_Z(1'b1, 1'b1));
        add(I_ENQ(2'b01, 32'h0000_0020, 32'h0000_0050, 1'b1, 1'b0),
            O_W(3'b001, 3'd7, 32'h0000_001C, 32'h0000_0040, 1'b0));
        add(I_IDLE(), O_W(3'b010, 3'd0, 32'h0000_0020, 32'h0000_0050, 1'b1));
        add(I_IDLE(), O_Z(1'b1, 1'b1));

        // ---- sweep with one stalled cycle ----
        add(I_RST(), O_Z(1'b0, 1'b0));
        add(I_IDLE(), O_C(3'd0));
        add(I_IDLE(), O_C(3'd1));
        add(I_STALL(), O_Z(1'b1, 1'b0));
        for (int i = 2; i < 8; i++) add(I_IDLE(), O_C(3'(i)));
        add(I_IDLE(), O_Z(1'b1, 1'b1));

        // ---- clear from RUN, then clear again mid-sweep restarts at 0 ----
        add(I_CLRQ(), O_Z(1'b1, 1'b1));
        add(I_IDLE(), O_C(3'd0));
        add(I_IDLE(), O_C(3'd1));
        add(I_CLRQ(), O_C(3'd2));
        for (int i = 0; i < 8; i++) add(I_IDLE(), O_C(3'(i)));
        add(I_IDLE(), O_Z(1'b1, 1'b1));

        foreach (tbl[n]) apply(tbl[n].i, tbl[n].o, $sformatf("vec%0d", n));

        // ---- fill queue under stall, then drain in order ----
        for (int k = 0; k < 4; k++)
            apply(I_ENQ(2'b00, 32'h0000_0100 + 32'(4*k), 32'hB000_0000 + 32'(k), 1'(k), 1'b1),
                  O_Z(1'b1, 1'b1), $sformatf("fill%0d", k));
        apply(I_ENQ(2'b01, 32'h0000_0200, 32'hDEAD_BEEF, 1'b1, 1'b1), O_Z(1'b0, 1'b1), "full");
        for (int k = 0; k < 4; k++) begin
            o = O_W(3'b001, 3'(k), 32'h0000_0100 + 32'(4*k), 32'hB000_0000 + 32'(k), 1'(k));
            if (k == 0) o.rdy = 1'b0;
            apply(I_IDLE(), o, $sformatf("drain%0d", k));
        end
        apply(I_IDLE(), O_Z(1'b1, 1'b1), "drained");

        // ---- clear with queued entries and a simultaneous enqueue ----
        apply(I_ENQ(2'b00, 32'h0000_0200, 32'h0000_0001, 1'b1, 1'b1), O_Z(1'b1, 1'b1), "q0");
        apply(I_ENQ(2'b01, 32'h0000_0204, 32'h0000_0002, 1'b1, 1'b1), O_Z(1'b1, 1'b1), "q1");
        begin
            in_t vi;
            vi     = I_ENQ(2'b00, 32'h0000_0208, 32'h0000_0003, 1'b1, 1'b0);
            vi.clr = 1'b1;
            apply(vi, O_Z(1'b1, 1'b1), "clr_enq");
        end
        for (int i = 0; i < 8; i++) apply(I_IDLE(), O_C(3'(i)), $sformatf("flush_sweep%0d", i));
        apply(I_IDLE(), O_Z(1'b1, 1'b1), "flushed0");
        apply(I_IDLE(), O_Z(1'b1, 1'b1), "flushed1");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
